// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction fetch stage. Owns the PC, issues word reads to instruction
//   memory, buffers returned words together with their PC in a small in-order
//   FIFO and hands them to decode. Absorbs memory latency and decode
//   backpressure. A redirect from execute flushes the queue and restarts fetch;
//   responses still owed for wrong-path requests are counted and dropped.
//
//   Ports
//     iCLK, iRST          clock (rising edge), async active-low reset
//     oIMemReq/oIMemAddr  read request valid / word address (= PC)
//     iIMemReady          memory accepts the request this cycle
//     iIMemRValid/RData   in-order read response, no backpressure
//     oValid/oInstr/oPC   entry presented to decode
//     iReady              decode consumes the entry this cycle
//     iRedirect/RedirectPC flush and restart at {iRedirectPC[31:2],2'b00}
//
//   Build option
//     FETCH_BYPASS_EN  when defined, a response arriving to an empty queue is
//                      presented to decode in the same cycle (combinational
//                      iIMemRData -> oInstr path). Undefined: outputs come
//                      only from queue registers.
// -----------------------------------------------------------------------------
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned MAX_OUT  = 2,
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic        iCLK,
   input  logic        iRST,
   output logic        oIMemReq,
   output logic [31:0] oIMemAddr,
   input  logic        iIMemReady,
   input  logic        iIMemRValid,
   input  logic [31:0] iIMemRData,
   output logic        oValid,
   output logic [31:0] oInstr,
   output logic [31:0] oPC,
   input  logic        iReady,
   input  logic        iRedirect,
   input  logic [31:0] iRedirectPC
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

   state_e                 state_q, state_d;
   logic [31:0]            pc_q, pc_d;
   logic [CW-1:0]          count_q, count_d;
   logic [CW-1:0]          out_q, out_d;
   logic [CW-1:0]          disc_q, disc_d;
   logic [AW-1:0]          rd_q, rd_d, wr_q, wr_d;
   logic [DEPTH-1:0][31:0] instr_q, epc_q;

   logic        accept, drop, push, fifo_pop, fifo_empty, byp;
   logic [31:0] resp_pc;

   assign fifo_empty = (count_q == '0);

   // Credit check: queued words plus words still owed must fit in the FIFO.
   assign oIMemReq  = (state_q == S_RUN) & ~iRedirect
                    & (({1'b0, count_q} + {1'b0, out_q}) < (CW+1)'(DEPTH))
                    & (out_q < CW'(MAX_OUT));
   assign oIMemAddr = pc_q;
   assign accept    = oIMemReq & iIMemReady;

   // With nothing to discard, every outstanding request is consecutive and
   // pc_q is one past the newest, so the oldest (responding) one sits at
   // pc_q - 4*outstanding.
   assign resp_pc = pc_q - {{(30-CW){1'b0}}, out_q, 2'b00};
   assign drop    = iIMemRValid & ((disc_q != '0) | iRedirect);

`ifdef FETCH_BYPASS_EN
   assign byp    = iIMemRValid & fifo_empty & (disc_q == '0) & ~iRedirect
                 & (state_q != S_IDLE);
   assign oValid = ~fifo_empty | byp;
   assign oInstr = byp ? iIMemRData : instr_q[rd_q];
   assign oPC    = byp ? resp_pc    : epc_q[rd_q];
   // A bypassed word taken by decode is never written.
   assign push   = iIMemRValid & ~drop & ~(byp & iReady);
`else
   assign byp    = 1'b0;
   assign oValid = ~fifo_empty;
   assign oInstr = instr_q[rd_q];
   assign oPC    = epc_q[rd_q];
   assign push   = iIMemRValid & ~drop;
`endif

   assign fifo_pop = iReady & ~fifo_empty;

   always_comb begin
      pc_d    = pc_q;
      count_d = count_q;
      out_d   = out_q + CW'(accept) - CW'(iIMemRValid);
      disc_d  = disc_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      state_d = state_q;

      if (accept)   pc_d = pc_q + 32'd4;
      if (push)     wr_d = wr_q + AW'(1);
      if (fifo_pop) rd_d = rd_q + AW'(1);
      if (push && !fifo_pop)      count_d = count_q + CW'(1);
      else if (!push && fifo_pop) count_d = count_q - CW'(1);
      if (iIMemRValid && disc_q != '0) disc_d = disc_q - CW'(1);

      // Redirect wins over everything: any pop above has already been counted
      // by decode, then the queue is emptied and every response still owed
      // after this cycle becomes a discard.
      if (iRedirect) begin
         count_d = '0;
         rd_d    = '0;
         wr_d    = '0;
         pc_d    = {iRedirectPC[31:2], 2'b00};
         disc_d  = out_q - CW'(iIMemRValid);
      end

      case (state_q)
         S_IDLE:         state_d = S_RUN;
         S_RUN, S_DRAIN: state_d = (disc_d != '0) ? S_DRAIN : S_RUN;
         default:        state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         count_q <= '0;
         out_q   <= '0;
         disc_q  <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         instr_q <= '0;
         epc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         count_q <= count_d;
         out_q   <= out_d;
         disc_q  <= disc_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         if (push) begin
            instr_q[wr_q] <= iIMemRData;
            epc_q[wr_q]   <= resp_pc;
         end
      end
   end

   a_push_full: assert property (@(posedge iCLK) disable iff (!iRST)
      push |-> (count_q != CW'(DEPTH)));
   a_out_uflow: assert property (@(posedge iCLK) disable iff (!iRST)
      iIMemRValid |-> (out_q != '0));
   a_disc_le_out: assert property (@(posedge iCLK) disable iff (!iRST)
      disc_q <= out_q);

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Random-stimulus bench for fetch_queue. The reference model tracks fetch
//   at the program level: a fetch PC, an epoch bumped on every redirect,
//   in-flight requests tagged with their epoch, and a queue of words waiting
//   for decode. A response is kept only if its epoch is still current.
// -----------------------------------------------------------------------------
module tb_fetch_queue;
   localparam int          DEPTH    = 4;
   localparam int          MAX_OUT  = 2;
   localparam logic [31:0] RESET_PC = 32'h0040_0000;
   localparam int          NCYC     = 2000;

   logic        iCLK = 1'b0, iRST = 1'b0;
   logic        oIMemReq, iIMemReady = 1'b0, iIMemRValid = 1'b0;
   logic [31:0] oIMemAddr, iIMemRData = '0;
   logic        oValid, iReady = 1'b0, iRedirect = 1'b0;
   logic [31:0] oInstr, oPC, iRedirectPC = '0;

   always #5 iCLK = ~iCLK;

   fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RESET_PC)) dut (
      .iCLK(iCLK), .iRST(iRST),
      .oIMemReq(oIMemReq), .oIMemAddr(oIMemAddr), .iIMemReady(iIMemReady),
      .iIMemRValid(iIMemRValid), .iIMemRData(iIMemRData),
      .oValid(oValid), .oInstr(oInstr), .oPC(oPC), .iReady(iReady),
      .iRedirect(iRedirect), .iRedirectPC(iRedirectPC)
   );

   typedef struct { logic [31:0] addr; int epoch; int due; } req_t;
   typedef struct { logic [31:0] pc; logic [31:0] w; } ent_t;

   int          n_chk = 0, n_err = 0;
   logic [31:0] m_pc;
   int          epoch, cyc, cur_lat;
   bit          started;
   req_t        pend[$];
   ent_t        mq[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d: got %08h want %08h", tag, cyc, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
   endfunction

   task automatic do_reset();
      #1 iRST = 1'b0;
      #1;
      chk("rst_req",   32'(oIMemReq), 32'd0);
      chk("rst_valid", 32'(oValid),   32'd0);
      chk("rst_instr", oInstr,        32'd0);
      chk("rst_pc",    oPC,           32'd0);
      iIMemRValid = 1'b0; iIMemReady = 1'b0; iReady = 1'b0; iRedirect = 1'b0;
      pend.delete(); mq.delete();
      m_pc = RESET_PC; epoch = 0; started = 1'b0;
      repeat (2) @(posedge iCLK);
      #2 iRST = 1'b1;
      #2;
      chk("idle_req",   32'(oIMemReq), 32'd0);
      chk("idle_valid", 32'(oValid),   32'd0);
      started = 1'b1;   // the coming edge moves the fetch unit into RUN
   endtask

   task automatic drive();
      if (cyc < 60) begin
         iReady = 1'b1; iIMemReady = 1'b1; iRedirect = 1'b0; cur_lat = 1;
      end else if (cyc < 80) begin
         iReady = 1'b0; iIMemReady = 1'b1; iRedirect = 1'b0; cur_lat = 1;
      end else begin
         iReady     = ($urandom % 4) != 0;
         iIMemReady = ($urandom % 3) != 0;
         iRedirect  = ($urandom % 16) == 0;
         cur_lat    = $urandom_range(1, 3);
      end
      case ($urandom % 4)
         0:       iRedirectPC = 32'h0040_0103;
         1:       iRedirectPC = 32'hFFFF_FFF4 | ($urandom % 4);
         default: iRedirectPC = 32'h0040_0000 + $urandom_range(0, 1023);
      endcase
      iIMemRValid = (pend.size() > 0) && (pend[0].due <= cyc);
      iIMemRData  = iIMemRValid ? mem_word(pend[0].addr) : $urandom;
   endtask

   initial begin
      bit   exp_req, exp_valid, draining, resp_drop, byp, accept;
      ent_t head;
      req_t p;
      cyc = 0;
      do_reset();
      while (cyc < NCYC) begin
         @(posedge iCLK);
         #1 drive();
         #4;
         draining = 1'b0;
         foreach (pend[i]) if (pend[i].epoch != epoch) draining = 1'b1;
         exp_req = started && !iRedirect && !draining
                && (mq.size() + pend.size() < DEPTH) && (pend.size() < MAX_OUT);
         chk("req", 32'(oIMemReq), 32'(exp_req));
         if (exp_req) chk("addr", oIMemAddr, m_pc);

         resp_drop = iIMemRValid && ((pend[0].epoch != epoch) || iRedirect);
`ifdef FETCH_BYPASS_EN
         byp = iIMemRValid && (mq.size() == 0) && !resp_drop;
`else
         byp = 1'b0;
`endif
         exp_valid = (mq.size() > 0) || byp;
         chk("valid", 32'(oValid), 32'(exp_valid));
         if (exp_valid) begin
            if (mq.size() > 0) head = mq[0];
            else               head = '{pend[0].addr, mem_word(pend[0].addr)};
            chk("pc",    oPC,    head.pc);
            chk("instr", oInstr, head.w);
         end

         // advance the model across the coming edge
         accept = exp_req && iIMemReady;
         if (exp_valid && iReady && mq.size() > 0) void'(mq.pop_front());
         if (iIMemRValid) begin
            p = pend.pop_front();
            if (!resp_drop && !(byp && iReady)) mq.push_back('{p.addr, mem_word(p.addr)});
         end
         if (iRedirect) begin
            mq.delete();
            epoch++;
            m_pc = {iRedirectPC[31:2], 2'b00};
         end else if (accept) begin
            pend.push_back('{m_pc, epoch, cyc + cur_lat});
            m_pc = m_pc + 32'd4;
         end
         cyc++;
         if (cyc == 1000) do_reset();   // asynchronous reset in the middle of traffic
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
